// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two requesters, the response consumer and the shared ALU.
// slave is the arbiter's view; master is the environment's view.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_val1;
  logic [31:0] req0_val2;
  logic [4:0]  req0_aluop;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_val1;
  logic [31:0] req1_val2;
  logic [4:0]  req1_aluop;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_divz;
  logic [31:0] alu_val1;
  logic [31:0] alu_val2;
  logic [4:0]  alu_aluop;
  logic        alu_is_alu_op;
  logic [31:0] alu_result;

  modport slave (
    input  req0_valid, req0_val1, req0_val2, req0_aluop,
    input  req1_valid, req1_val1, req1_val2, req1_aluop,
    input  rsp_ready, alu_result,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_divz,
    output alu_val1, alu_val2, alu_aluop, alu_is_alu_op
  );

  modport master (
    output req0_valid, req0_val1, req0_val2, req0_aluop,
    output req1_valid, req1_val1, req1_val2, req1_aluop,
    output rsp_ready, alu_result,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_divz,
    input  alu_val1, alu_val2, alu_aluop, alu_is_alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are held for a per-opcode latency so MUL/DIV can be multicycle paths.
module alu_arbiter #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  localparam int unsigned DATA_W = 32;
  localparam logic [4:0] ALUOP_MUL = 5'd10;
  localparam logic [4:0] ALUOP_DIV = 5'd11;
  localparam logic [3:0] MUL_LAT   = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LAT   = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q;
  logic                last_grant_q;
  logic [3:0]          cnt_q;
  logic                op_id_q;
  logic [DATA_W-1:0]   alu_val1_q;
  logic [DATA_W-1:0]   alu_val2_q;
  logic [4:0]          alu_aluop_q;
  logic                alu_is_q;
  logic                rsp_valid_q;
  logic                rsp_id_q;
  logic [DATA_W-1:0]   rsp_result_q;
  logic                rsp_divz_q;

  logic                grant_d;
  logic                accept_d;
  logic [DATA_W-1:0]   op_val1_d;
  logic [DATA_W-1:0]   op_val2_d;
  logic [4:0]          op_aluop_d;
  logic [3:0]          lat_d;
  logic                divz_d;

  // A tie goes to the requester that was not granted last.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) grant_d = ~last_grant_q;
    else                                  grant_d = bus.req1_valid;
  end

  assign bus.req0_ready = (state_q == IDLE) && !grant_d && bus.req0_valid;
  assign bus.req1_ready = (state_q == IDLE) &&  grant_d && bus.req1_valid;
  assign accept_d       = bus.req0_ready || bus.req1_ready;

  assign op_val1_d  = grant_d ? bus.req1_val1  : bus.req0_val1;
  assign op_val2_d  = grant_d ? bus.req1_val2  : bus.req0_val2;
  assign op_aluop_d = grant_d ? bus.req1_aluop : bus.req0_aluop;
  assign divz_d     = (op_aluop_d == ALUOP_DIV) && (op_val2_d == '0);

  always_comb begin
    lat_d = 4'd1;
    if (op_aluop_d == ALUOP_MUL)      lat_d = MUL_LAT;
    else if (op_aluop_d == ALUOP_DIV) lat_d = DIV_LAT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      op_id_q      <= 1'b0;
      alu_val1_q   <= '0;
      alu_val2_q   <= '0;
      alu_aluop_q  <= '0;
      alu_is_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_divz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            op_id_q      <= grant_d;
            last_grant_q <= grant_d;
            cnt_q        <= lat_d;
            if (divz_d) begin
              // Divide by zero never reaches the ALU.
              state_q      <= RESP;
              rsp_valid_q  <= 1'b1;
              rsp_id_q     <= grant_d;
              rsp_result_q <= '1;
              rsp_divz_q   <= 1'b1;
            end else begin
              state_q     <= EXEC;
              alu_val1_q  <= op_val1_d;
              alu_val2_q  <= op_val2_d;
              alu_aluop_q <= op_aluop_d;
              alu_is_q    <= 1'b1;
            end
          end
        end
        EXEC: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q      <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= op_id_q;
            rsp_result_q <= bus.alu_result;
            rsp_divz_q   <= 1'b0;
            alu_val1_q   <= '0;
            alu_val2_q   <= '0;
            alu_aluop_q  <= '0;
            alu_is_q     <= 1'b0;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_result    = rsp_result_q;
  assign bus.rsp_divz      = rsp_divz_q;
  assign bus.alu_val1      = alu_val1_q;
  assign bus.alu_val2      = alu_val2_q;
  assign bus.alu_aluop     = alu_aluop_q;
  assign bus.alu_is_alu_op = alu_is_q;

endmodule
